display_mux_7seg: RTL and testbench

DISPLAY_MUX_7SEG -- requirements
Module: display_mux_7seg

---
 rtl/display_pkg.sv | 30 +++
 rtl/bcd_to_seg.sv | 26 ++
 rtl/display_mux_7seg.sv | 156 +++++++++++++++
 tb/tb_display_mux_7seg.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared seven-segment definitions for the display blocks.
// Patterns are active-high, bit 0 = segment a through bit 6 = segment g.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b011_1111;
    localparam logic [6:0] SEG_1     = 7'b000_0110;
    localparam logic [6:0] SEG_2     = 7'b101_1011;
    localparam logic [6:0] SEG_3     = 7'b100_1111;
    localparam logic [6:0] SEG_4     = 7'b110_0110;
    localparam logic [6:0] SEG_5     = 7'b110_1101;
    localparam logic [6:0] SEG_6     = 7'b111_1101;
    localparam logic [6:0] SEG_7     = 7'b000_0111;
    localparam logic [6:0] SEG_8     = 7'b111_1111;
    localparam logic [6:0] SEG_9     = 7'b110_1111;
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    typedef logic [3:0] bcd_t;

    // Everything needed to drive one digit slot, before polarity.
    typedef struct packed {
        bcd_t value;
        logic blank;
        logic dp;
    } digit_view_t;

    function automatic logic [6:0] seg_polarity(input logic [6:0] lit, input logic active_low);
        return active_low ? ~lit : lit;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// BCD to active-high seven-segment decoder; codes above 9 decode to blank.
module bcd_to_seg
    import display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure lookup, no state.
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_mux_7seg.sv
// Time-multiplexed seven-segment driver with shadowed digit data,
// leading-zero suppression and registered, polarity-configurable outputs.
module display_mux_7seg
    import display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic                  SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic                  AN_INV  = (AN_ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF = seg_polarity(SEG_BLANK, SEG_INV);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_INV}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] bcd_sh_q;
    logic [NUM_DIGITS-1:0]   blank_sh_q;
    logic [NUM_DIGITS-1:0]   dp_sh_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    tick_s;
    logic [NUM_DIGITS-1:0]   lz_mask_s;
    logic [NUM_DIGITS-1:0]   an_hot_s;
    digit_view_t             sel_s;
    logic [6:0]              dec_seg_s;

    // Prescaler and digit index next state.
    always_comb begin
        tick_s = (cnt_q == CNT_MAX);
        if (tick_s) begin
            cnt_d = '0;
            if (idx_q == IDX_MAX) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
    end

    // Digit k is suppressed when it and every digit above it are zero.
    always_comb begin : lz_scan
        logic upper_zero;
        upper_zero = 1'b1;
        lz_mask_s  = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero   = upper_zero & (bcd_sh_q[4*k +: 4] == 4'd0);
            lz_mask_s[k] = lz_en & upper_zero;
        end
    end

    // Select the digit that becomes active at the next tick.
    always_comb begin
        sel_s    = '0;
        an_hot_s = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                sel_s.value = bcd_sh_q[4*k +: 4];
                sel_s.blank = blank_sh_q[k] | lz_mask_s[k];
                sel_s.dp    = dp_sh_q[k];
                an_hot_s[k] = 1'b1;
            end else begin
                an_hot_s[k] = 1'b0;
            end
        end
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd_i (sel_s.value),
        .seg_o (dec_seg_s)
    );

    // Output next state: reload only on tick, otherwise hold the slot.
    always_comb begin
        if (tick_s) begin
            seg_d = seg_polarity(sel_s.blank ? SEG_BLANK : dec_seg_s, SEG_INV);
            dp_d  = sel_s.dp ^ SEG_INV;
            an_d  = an_hot_s ^ AN_OFF;
        end else begin
            seg_d = seg_q;
            dp_d  = dp_q;
            an_d  = an_q;
        end
    end

    // Prescaler and scan index; index starts at the last digit so tick one shows digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= IDX_MAX;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Shadow copy of the host data; the scan never sees the live inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_sh_q   <= '0;
            blank_sh_q <= '0;
            dp_sh_q    <= '0;
        end else if (load) begin
            bcd_sh_q   <= bcd_in;
            blank_sh_q <= blank_in;
            dp_sh_q    <= dp_in;
        end else begin
            bcd_sh_q   <= bcd_sh_q;
            blank_sh_q <= blank_sh_q;
            dp_sh_q    <= dp_sh_q;
        end
    end

    // Output registers, already at physical polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_OFF;
            dp_q  <= SEG_INV;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_display_mux_7seg.sv
// Self-checking bench for display_mux_7seg: 4 digits, 4-cycle slots, active-low outputs.
module tb_display_mux_7seg;

    localparam logic [6:0] S0 = 7'b011_1111;
    localparam logic [6:0] S1 = 7'b000_0110;
    localparam logic [6:0] S2 = 7'b101_1011;
    localparam logic [6:0] S3 = 7'b100_1111;
    localparam logic [6:0] S4 = 7'b110_0110;
    localparam logic [6:0] S5 = 7'b110_1101;
    localparam logic [6:0] S6 = 7'b111_1101;
    localparam logic [6:0] S7 = 7'b000_0111;
    localparam logic [6:0] S8 = 7'b111_1111;
    localparam logic [6:0] S9 = 7'b110_1111;
    localparam logic [6:0] SB = 7'b000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  blank_in = 4'b0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        lz_en = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    display_mux_7seg #(
        .NUM_DIGITS     (4),
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_in    (bcd_in),
        .load      (load),
        .blank_in  (blank_in),
        .dp_in     (dp_in),
        .lz_en     (lz_en),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    // Inputs plus the expected active-high pattern of each digit {d3,d2,d1,d0}.
    typedef struct {
        logic [15:0]     bcd;
        logic [3:0]      blank;
        logic [3:0]      dpv;
        logic            lz;
        logic [3:0][6:0] exp_seg;
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
    } obs_t;

    vec_t vecs [7];
    obs_t sb_q [$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic obs_t make_exp(input logic [6:0] lit, input logic dpb, input int k);
        obs_t       e;
        logic [3:0] one;
        one   = 4'b0001;
        e.an  = ~(one << k);
        e.seg = ~lit;
        e.dp  = ~dpb;
        e.idx = 2'(k);
        return e;
    endfunction

    task automatic check_slot(input string name);
        obs_t got;
        obs_t exp;
        got = {an, seg, dp, digit_idx};
        n_total++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got an=%b seg=%b dp=%b idx=%0d",
                     name, got.an, got.seg, got.dp, got.idx);
        end else begin
            exp = sb_q.pop_front();
            if (got === exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got an=%b seg=%b dp=%b idx=%0d, expected an=%b seg=%b dp=%b idx=%0d",
                         name, got.an, got.seg, got.dp, got.idx, exp.an, exp.seg, exp.dp, exp.idx);
            end
        end
    endtask

    task automatic check_now(input string name, input obs_t exp);
        obs_t got;
        got = {an, seg, dp, digit_idx};
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got an=%b seg=%b dp=%b idx=%0d, expected an=%b seg=%b dp=%b idx=%0d",
                     name, got.an, got.seg, got.dp, got.idx, exp.an, exp.seg, exp.dp, exp.idx);
        end
    endtask

    task automatic drive_load(input vec_t v);
        bcd_in   = v.bcd;
        blank_in = v.blank;
        dp_in    = v.dpv;
        lz_en    = v.lz;
        load     = 1'b1;
    endtask

    // Entered #1 after a tick edge that left digit 3 showing (prescaler at 0).
    task automatic run_vec(input vec_t v, input string name);
        drive_load(v);
        for (int k = 0; k < 4; k++) sb_q.push_back(make_exp(v.exp_seg[k], v.dpv[k], k));
        @(posedge clk); #1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_slot($sformatf("%s d0", name));
        for (int k = 1; k < 4; k++) begin
            repeat (4) @(posedge clk);
            #1;
            check_slot($sformatf("%s d%0d", name, k));
        end
    endtask

    initial begin
        vec_t old_v;
        vec_t new_v;

        vecs[0] = '{bcd: 16'h1234, blank: 4'b0000, dpv: 4'b0000, lz: 1'b0, exp_seg: {S1, S2, S3, S4}};
        vecs[1] = '{bcd: 16'h0050, blank: 4'b0000, dpv: 4'b0000, lz: 1'b1, exp_seg: {SB, SB, S5, S0}};
        vecs[2] = '{bcd: 16'h0000, blank: 4'b0000, dpv: 4'b0000, lz: 1'b1, exp_seg: {SB, SB, SB, S0}};
        vecs[3] = '{bcd: 16'h00AF, blank: 4'b0100, dpv: 4'b0010, lz: 1'b0, exp_seg: {S0, SB, SB, SB}};
        vecs[4] = '{bcd: 16'h9876, blank: 4'b0000, dpv: 4'b1111, lz: 1'b0, exp_seg: {S9, S8, S7, S6}};
        vecs[5] = '{bcd: 16'h0705, blank: 4'b0001, dpv: 4'b0000, lz: 1'b1, exp_seg: {SB, S7, S0, SB}};
        vecs[6] = '{bcd: 16'h0008, blank: 4'b0000, dpv: 4'b1000, lz: 1'b1, exp_seg: {SB, SB, SB, S8}};

        repeat (3) @(posedge clk);
        #1;
        check_now("reset state", {4'b1111, 7'h7F, 1'b1, 2'd3});
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Load coinciding with a tick: slot 0 still shows the old shadow.
        old_v = '{bcd: 16'h1111, blank: 4'b0000, dpv: 4'b0000, lz: 1'b0, exp_seg: {S1, S1, S1, S1}};
        new_v = '{bcd: 16'h2222, blank: 4'b0000, dpv: 4'b0000, lz: 1'b0, exp_seg: {S2, S2, S2, S2}};
        run_vec(old_v, "pre");
        repeat (3) @(posedge clk);
        #1;
        drive_load(new_v);
        sb_q.push_back(make_exp(S1, 1'b0, 0));
        for (int k = 1; k < 4; k++) sb_q.push_back(make_exp(S2, 1'b0, k));
        @(posedge clk); #1;
        load = 1'b0;
        check_slot("coincide d0 old");
        for (int k = 1; k < 4; k++) begin
            repeat (4) @(posedge clk);
            #1;
            check_slot($sformatf("coincide d%0d new", k));
        end

        // Asynchronous reset in the middle of a slot, then restart timing.
        repeat (2) @(posedge clk);
        #2;
        check_now("before async reset", {4'b0111, ~S2, 1'b1, 2'd3});
        rst_n = 1'b0;
        #1;
        check_now("async reset no edge", {4'b1111, 7'h7F, 1'b1, 2'd3});
        #2;
        lz_en = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_now("dark before first tick", {4'b1111, 7'h7F, 1'b1, 2'd3});
        @(posedge clk); #1;
        check_now("first digit after reset", {4'b1110, ~S0, 1'b1, 2'd0});
        repeat (4) @(posedge clk);
        #1;
        check_now("shadow cleared d1", {4'b1101, ~S0, 1'b1, 2'd1});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
